// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state encoding, width defaults and trigger compare for the logic analyzer
package la_pkg;

  localparam int LA_DW = 16;
  localparam int LA_AW = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } la_state_e;

  function automatic logic la_trig_hit(input logic [LA_DW-1:0] sample,
                                       input logic [LA_DW-1:0] value,
                                       input logic [LA_DW-1:0] mask,
                                       input logic             force_trig);
    return (((sample ^ value) & mask) == '0) || force_trig;
  endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// rtl/la_capture_ctrl_if.sv - probe sample stream plus BRAM write port bundle
interface la_capture_ctrl_if #(
  parameter int DW = la_pkg::LA_DW,
  parameter int AW = la_pkg::LA_AW
);
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output sample, sample_valid, input we, addr, data);
  modport slave  (input sample, sample_valid, output we, addr, data);
endinterface

// File: rtl/la_trig_match.sv
// rtl/la_trig_match.sv - combinational mask/value trigger comparator with force override
module la_trig_match
  import la_pkg::*;
(
  input  logic [LA_DW-1:0] sample_i,
  input  logic [LA_DW-1:0] mask_i,
  input  logic [LA_DW-1:0] value_i,
  input  logic             force_i,
  output logic             hit_o
);

  assign hit_o = la_trig_hit(sample_i, value_i, mask_i, force_i);

endmodule

// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - pre/post-trigger circular capture into the sample BRAM
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int DW = LA_DW,
  parameter int AW = LA_AW
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic [DW-1:0] in_sample,
  input  logic          in_sample_valid,
  input  logic          in_arm,
  input  logic          in_abort,
  input  logic          in_force_trig,
  input  logic [DW-1:0] in_trig_mask,
  input  logic [DW-1:0] in_trig_value,
  input  logic [AW-1:0] in_pretrig,
  input  logic [AW-1:0] in_posttrig,
  input  logic [AW-1:0] in_rd_addr,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_armed,
  output logic          out_triggered,
  output logic          out_done,
  output logic [AW-1:0] out_trig_addr,
  output logic [AW-1:0] out_start_addr
);

  la_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] pre_cnt_q, pre_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [DW-1:0] mask_q, mask_d;
  logic [DW-1:0] value_q, value_d;
  logic [AW-1:0] pretrig_q, pretrig_d;
  logic [AW-1:0] posttrig_q, posttrig_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;
  logic          hit;

  la_trig_match u_trig_match (
    .sample_i (in_sample),
    .mask_i   (mask_q),
    .value_i  (value_q),
    .force_i  (in_force_trig),
    .hit_o    (hit)
  );

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    mask_d       = mask_q;
    value_d      = value_q;
    pretrig_d    = pretrig_q;
    posttrig_d   = posttrig_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    data_d       = data_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;

    if (in_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_arm) begin
            mask_d     = in_trig_mask;
            value_d    = in_trig_value;
            pretrig_d  = in_pretrig;
            posttrig_d = in_posttrig;
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            state_d    = (in_pretrig == '0) ? S_WAIT_TRIG : S_FILL;
          end
        end
        S_FILL, S_WAIT_TRIG: begin
          if (in_sample_valid) begin
            we_d      = 1'b1;
            waddr_d   = wr_ptr_q;
            data_d    = in_sample;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            pre_cnt_d = (pre_cnt_q == '1) ? pre_cnt_q : pre_cnt_q + 1'b1;
            // FILL never qualifies a trigger; it only hands over once enough history exists
            if (state_q == S_FILL) begin
              if (pre_cnt_d >= pretrig_q) state_d = S_WAIT_TRIG;
            end else if (hit) begin
              trig_addr_d  = wr_ptr_q;
              start_addr_d = wr_ptr_q - pretrig_q;
              post_cnt_d   = '0;
              state_d      = S_POST;
            end
          end
        end
        S_POST: begin
          // Completion is checked before accepting a sample, so DONE lands one cycle after the last write
          if (post_cnt_q >= posttrig_q) begin
            state_d = S_DONE;
          end else if (in_sample_valid) begin
            we_d       = 1'b1;
            waddr_d    = wr_ptr_q;
            data_d     = in_sample;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            post_cnt_d = post_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      pretrig_q    <= '0;
      posttrig_q   <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      pretrig_q    <= pretrig_d;
      posttrig_q   <= posttrig_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  // Readout owns the address port whenever no capture is running
  assign out_addr       = (state_q == S_IDLE || state_q == S_DONE) ? in_rd_addr : waddr_q;
  assign out_we         = we_q;
  assign out_data       = data_q;
  assign out_armed      = (state_q == S_FILL) || (state_q == S_WAIT_TRIG);
  assign out_triggered  = (state_q == S_POST) || (state_q == S_DONE);
  assign out_done       = (state_q == S_DONE);
  assign out_trig_addr  = trig_addr_q;
  assign out_start_addr = start_addr_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb/tb_la_capture_ctrl.sv - scoreboard bench for la_capture_ctrl
module tb_la_capture_ctrl;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        in_clk;
  logic        in_rst;
  logic        in_arm;
  logic        in_abort;
  logic        in_force_trig;
  logic [15:0] in_trig_mask;
  logic [15:0] in_trig_value;
  logic [9:0]  in_pretrig;
  logic [9:0]  in_posttrig;
  logic [9:0]  in_rd_addr;
  logic        out_armed;
  logic        out_triggered;
  logic        out_done;
  logic [9:0]  out_trig_addr;
  logic [9:0]  out_start_addr;

  la_capture_ctrl_if #(.DW(16), .AW(10)) bus ();

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wcount = 0;

  la_capture_ctrl #(.DW(16), .AW(10)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_sample       (bus.sample),
    .in_sample_valid (bus.sample_valid),
    .in_arm          (in_arm),
    .in_abort        (in_abort),
    .in_force_trig   (in_force_trig),
    .in_trig_mask    (in_trig_mask),
    .in_trig_value   (in_trig_value),
    .in_pretrig      (in_pretrig),
    .in_posttrig     (in_posttrig),
    .in_rd_addr      (in_rd_addr),
    .out_we          (bus.we),
    .out_addr        (bus.addr),
    .out_data        (bus.data),
    .out_armed       (out_armed),
    .out_triggered   (out_triggered),
    .out_done        (out_done),
    .out_trig_addr   (out_trig_addr),
    .out_start_addr  (out_start_addr)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge in_clk) begin
    if (!in_rst && bus.we) begin
      wr_t e;
      wcount++;
      chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", {22'd0, bus.addr}, {22'd0, e.addr});
        chk("write_data", {16'd0, bus.data}, {16'd0, e.data});
      end
    end
  end

  task automatic arm_cfg(input logic [15:0] mask, input logic [15:0] value,
                         input logic [9:0] pre, input logic [9:0] post);
    in_trig_mask  = mask;
    in_trig_value = value;
    in_pretrig    = pre;
    in_posttrig   = post;
    in_arm        = 1'b1;
    @(posedge in_clk); #1;
    in_arm        = 1'b0;
    in_trig_mask  = 16'hFFFF;
    in_trig_value = 16'hA5A5;
    in_pretrig    = 10'h3FF;
    in_posttrig   = 10'h3FF;
  endtask

  task automatic run_cap(input logic [15:0] mask, input logic [15:0] value,
                         input logic [9:0] pre, input logic [9:0] post,
                         input int trig_idx, input int fill_idx, input bit gaps,
                         input bit arm_post, input logic [9:0] exp_trig,
                         input logic [9:0] exp_start);
    int          last;
    int          n;
    logic [15:0] s;
    last   = trig_idx + int'(post);
    n      = last + 3;
    wcount = 0;
    arm_cfg(mask, value, pre, post);
    chk("armed_after_arm", {31'd0, out_armed}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.sample_valid = 1'b0;
        bus.sample       = value;
        @(posedge in_clk); #1;
      end
      s = (i == trig_idx || i == fill_idx) ? value : i[15:0];
      bus.sample       = s;
      bus.sample_valid = 1'b1;
      in_arm           = arm_post && (i == trig_idx + 1);
      if (i <= last) exp_q.push_back('{addr: i[9:0], data: s});
      @(posedge in_clk); #1;
      in_arm = 1'b0;
      if (i == trig_idx) begin
        chk("trig_rise", {31'd0, out_triggered}, 32'd1);
        chk("armed_fall", {31'd0, out_armed}, 32'd0);
      end
      if (i == last) chk("done_low_at_last_write", {31'd0, out_done}, 32'd0);
      if (i == last + 1) chk("done_after_last_write", {31'd0, out_done}, 32'd1);
    end
    bus.sample_valid = 1'b0;
    chk("done", {31'd0, out_done}, 32'd1);
    chk("triggered_in_done", {31'd0, out_triggered}, 32'd1);
    chk("trig_addr", {22'd0, out_trig_addr}, {22'd0, exp_trig});
    chk("start_addr", {22'd0, out_start_addr}, {22'd0, exp_start});
    chk("write_count", wcount, last + 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    in_rst           = 1'b1;
    in_arm           = 1'b0;
    in_abort         = 1'b0;
    in_force_trig    = 1'b0;
    in_trig_mask     = '0;
    in_trig_value    = '0;
    in_pretrig       = '0;
    in_posttrig      = '0;
    in_rd_addr       = '0;
    bus.sample       = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    chk("rst_we", {31'd0, bus.we}, 32'd0);
    chk("rst_status", {29'd0, out_armed, out_triggered, out_done}, 32'd0);
    chk("rst_trig_addr", {22'd0, out_trig_addr}, 32'd0);
    in_rst = 1'b0;
    @(posedge in_clk); #1;

    // basic mask/value trigger with history and post window
    run_cap(16'h00FF, 16'h0055, 10'd4, 10'd3, 6, -1, 1'b0, 1'b0, 10'd6, 10'd2);
    in_rd_addr = 10'h155;
    #1;
    chk("readout_addr_mux", {22'd0, bus.addr}, 32'h155);
    in_rd_addr = 10'd0;

    // match during FILL ignored, idle gaps in the stream
    run_cap(16'h00FF, 16'h0055, 10'd4, 10'd3, 8, 2, 1'b1, 1'b0, 10'd8, 10'd4);

    // mask 0, no history, no post window
    run_cap(16'h0000, 16'h0000, 10'd0, 10'd0, 0, -1, 1'b0, 1'b0, 10'd0, 10'd0);

    // long capture that wraps the buffer
    run_cap(16'hFFFF, 16'hBEEF, 10'd1000, 10'd100, 1500, -1, 1'b0, 1'b0, 10'd476, 10'd500);

    // arm pulse while in POST must not restart
    run_cap(16'hFFFF, 16'hBEEF, 10'd2, 10'd3, 5, -1, 1'b0, 1'b1, 10'd5, 10'd3);

    // abort in WAIT_TRIG with a matching valid sample
    wcount = 0;
    arm_cfg(16'hFFFF, 16'hBEEF, 10'd2, 10'd3);
    for (int i = 0; i < 3; i++) begin
      bus.sample       = i[15:0];
      bus.sample_valid = 1'b1;
      exp_q.push_back('{addr: i[9:0], data: i[15:0]});
      @(posedge in_clk); #1;
    end
    chk("abort_pre_armed", {31'd0, out_armed}, 32'd1);
    bus.sample = 16'hBEEF;
    in_abort   = 1'b1;
    @(posedge in_clk); #1;
    in_abort         = 1'b0;
    bus.sample_valid = 1'b0;
    chk("abort_no_we", {31'd0, bus.we}, 32'd0);
    chk("abort_idle", {30'd0, out_armed, out_triggered}, 32'd0);
    @(posedge in_clk); #1;
    chk("abort_write_count", wcount, 3);
    chk("abort_queue", exp_q.size(), 0);

    // async reset while in POST
    arm_cfg(16'h00FF, 16'h0055, 10'd4, 10'd3);
    for (int i = 0; i < 8; i++) begin
      bus.sample       = (i == 6) ? 16'h0055 : i[15:0];
      bus.sample_valid = 1'b1;
      exp_q.push_back('{addr: i[9:0], data: bus.sample});
      @(posedge in_clk); #1;
    end
    bus.sample_valid = 1'b0;
    chk("pre_reset_in_post", {31'd0, out_triggered}, 32'd1);
    #2;
    in_rst = 1'b1;
    #1;
    chk("midrst_we", {31'd0, bus.we}, 32'd0);
    chk("midrst_status", {29'd0, out_armed, out_triggered, out_done}, 32'd0);
    chk("midrst_addr_data", {6'd0, bus.addr, bus.data}, 32'd0);
    chk("midrst_trig_start", {12'd0, out_trig_addr, out_start_addr}, 32'd0);
    exp_q.delete();
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    @(posedge in_clk); #1;
    run_cap(16'h00FF, 16'h0055, 10'd4, 10'd3, 6, -1, 1'b0, 1'b0, 10'd6, 10'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
